// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade/PWM block: channel state encodings and
// the helper that derives the full-brightness level from the PWM width.
// Build option: LED_FADE_GAMMA_EN (see led_fade_channel).
package led_fade_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } led_state_t;

  // Full-brightness level for an n-bit PWM: 2^n - 1
  function automatic int unsigned max_level(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: ramp FSM, brightness level register and PWM compare.
// Build option LED_FADE_GAMMA_EN squares the level (gamma ~2) before the
// compare, at the cost of one extra pipeline stage on the output.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_OFF       | level held at 0, waiting for a request
// ST_RAMP_UP   | level +1 per step tick until max, then ST_ON
// ST_ON        | level held at max, waiting for request to drop
// ST_RAMP_DOWN | level -1 per step tick until 0, then ST_OFF
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned p_pwm_bits = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_step_tick,
  input  logic [p_pwm_bits-1:0] i_pwm_cnt,
  output logic                  o_pwm,
  output logic                  o_ramping
);

  localparam logic [p_pwm_bits-1:0] LVL_MAX    = p_pwm_bits'(max_level(p_pwm_bits));
  localparam logic [p_pwm_bits-1:0] LVL_ONE    = p_pwm_bits'(1);
  localparam logic [p_pwm_bits-1:0] LVL_MAX_M1 = LVL_MAX - LVL_ONE;

  led_state_t            state;
  logic [p_pwm_bits-1:0] level;

  // Ramp FSM and level register; the level step always uses the pre-edge state
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_OFF;
      level <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          level <= '0;
          if (i_req) state <= ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (i_step_tick && (level != LVL_MAX)) level <= level + LVL_ONE;
          if (!i_req) state <= ST_RAMP_DOWN;
          else if (i_step_tick && (level >= LVL_MAX_M1)) state <= ST_ON;
        end
        ST_ON: begin
          level <= LVL_MAX;
          if (!i_req) state <= ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (i_step_tick && (level != '0)) level <= level - LVL_ONE;
          if (i_req) state <= ST_RAMP_UP;
          else if (i_step_tick && (level <= LVL_ONE)) state <= ST_OFF;
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  assign o_ramping = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);

`ifdef LED_FADE_GAMMA_EN
  logic [2*p_pwm_bits-1:0] lvl_sq;
  logic [p_pwm_bits-1:0]   eff_level_q;
  logic [p_pwm_bits-1:0]   pwm_cnt_q;

  assign lvl_sq = {{p_pwm_bits{1'b0}}, level} * {{p_pwm_bits{1'b0}}, level};

  // Gamma stage: register the squared level and delay the counter to match
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      eff_level_q <= '0;
      pwm_cnt_q   <= '0;
      o_pwm       <= 1'b0;
    end else begin
      eff_level_q <= p_pwm_bits'(lvl_sq >> p_pwm_bits);
      pwm_cnt_q   <= i_pwm_cnt;
      o_pwm       <= (pwm_cnt_q < eff_level_q);
    end
  end
`else
  // PWM compare against the raw level, registered
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_pwm <= 1'b0;
    else        o_pwm <= (i_pwm_cnt < level);
  end
`endif

endmodule

// File: rtl/led_fade_pwm.sv
// RGB LED fader: turns on/off requests into smoothly ramped PWM drive.
// Holds the shared step-tick divider, the free-running PWM counter and the
// busy flag; per-channel logic lives in led_fade_channel.
// Build option LED_FADE_GAMMA_EN enables gamma correction in each channel.
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int unsigned p_pwm_bits = 8,
  parameter int unsigned p_step_div = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_led_r,
  input  logic i_led_g,
  input  logic i_led_b,
  output logic o_led_r,
  output logic o_led_g,
  output logic o_led_b,
  output logic o_busy
);

  localparam int unsigned      DIV_W    = (p_step_div > 1) ? $clog2(p_step_div) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(p_step_div - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic                  step_tick;
  logic [p_pwm_bits-1:0] pwm_cnt;
  logic                  ramp_r;
  logic                  ramp_g;
  logic                  ramp_b;

  assign step_tick = (div_cnt == DIV_LAST);

  // Step tick divider: 0..p_step_div-1, tick on the last count
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)         div_cnt <= '0;
    else if (step_tick) div_cnt <= '0;
    else                div_cnt <= div_cnt + DIV_W'(1);
  end

  // Free-running PWM counter shared by all channels
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + p_pwm_bits'(1);
  end

  // Busy while any channel is ramping
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_busy <= 1'b0;
    else        o_busy <= ramp_r | ramp_g | ramp_b;
  end

  led_fade_channel #(.p_pwm_bits(p_pwm_bits)) u_ch_r (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_led_r),
    .i_step_tick (step_tick),
    .i_pwm_cnt   (pwm_cnt),
    .o_pwm       (o_led_r),
    .o_ramping   (ramp_r)
  );

  led_fade_channel #(.p_pwm_bits(p_pwm_bits)) u_ch_g (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_led_g),
    .i_step_tick (step_tick),
    .i_pwm_cnt   (pwm_cnt),
    .o_pwm       (o_led_g),
    .o_ramping   (ramp_g)
  );

  led_fade_channel #(.p_pwm_bits(p_pwm_bits)) u_ch_b (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_led_b),
    .i_step_tick (step_tick),
    .i_pwm_cnt   (pwm_cnt),
    .o_pwm       (o_led_b),
    .o_ramping   (ramp_b)
  );

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: a fast instance (4-bit PWM, step every 4 cycles)
// for ramp/reverse/reset timing and a slow instance (step every 1000 cycles)
// for duty measurement between ticks. Expected levels are queued with the
// cycle they must appear on; expected duties are queued before measuring.
module tb_led_fade_pwm;
  import led_fade_pkg::*;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int DIV_S = 1000;

  logic r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  logic rst_n, led_r, led_g, led_b;
  logic out_r, out_g, out_b, busy;
  logic rst_s, led_b_s;
  logic out_r_s, out_g_s, out_b_s, busy_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cyc;
    int lvl;
  } exp_t;

  exp_t sb_q[$];
  int   duty_q[$];

  led_fade_pwm #(.p_pwm_bits(N), .p_step_div(DIV)) u_dut (
    .i_clk   (r_clk),
    .i_rst   (rst_n),
    .i_led_r (led_r),
    .i_led_g (led_g),
    .i_led_b (led_b),
    .o_led_r (out_r),
    .o_led_g (out_g),
    .o_led_b (out_b),
    .o_busy  (busy)
  );

  led_fade_pwm #(.p_pwm_bits(N), .p_step_div(DIV_S)) u_slow (
    .i_clk   (r_clk),
    .i_rst   (rst_s),
    .i_led_r (1'b0),
    .i_led_g (1'b0),
    .i_led_b (led_b_s),
    .o_led_r (out_r_s),
    .o_led_g (out_g_s),
    .o_led_b (out_b_s),
    .o_busy  (busy_s)
  );

  function automatic int eff_model(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) >> N;
`else
    return l;
`endif
  endfunction

  function automatic int lvl(input int ch);
    case (ch)
      0:       return int'(u_dut.u_ch_r.level);
      1:       return int'(u_dut.u_ch_g.level);
      2:       return int'(u_dut.u_ch_b.level);
      default: return int'(u_slow.u_ch_b.level);
    endcase
  endfunction

  function automatic logic led_out(input int ch);
    case (ch)
      0:       return out_r;
      1:       return out_g;
      2:       return out_b;
      default: return out_b_s;
    endcase
  endfunction

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge r_clk);
      if (led_out(ch) === 1'b1) hi++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_s = 1'b0;
    led_r = 1'b0; led_g = 1'b0; led_b = 1'b0; led_b_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge r_clk);
      n_tests++;
      if ({out_r, out_g, out_b, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0000", i, {out_r, out_g, out_b, busy});
      end
      n_tests++;
      if ({out_r_s, out_g_s, out_b_s, busy_s} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs_slow cyc=%0d got=%b exp=0000", i, {out_r_s, out_g_s, out_b_s, busy_s});
      end
      {led_r, led_g, led_b, led_b_s} = 4'($urandom);
    end
    @(negedge r_clk);
    led_r = 1'b0; led_g = 1'b0; led_b = 1'b0; led_b_s = 1'b0;
  endtask

  task automatic test_ramp_up();
    exp_t e;
    int   hi;
    @(negedge r_clk);
    rst_n = 1'b1;
    led_r = 1'b1;
    sb_q.delete();
    for (int k = 1; k <= 15; k++) sb_q.push_back('{cyc: DIV * k, lvl: k});
    for (int c = 1; c <= DIV * 16 && sb_q.size() > 0; c++) begin
      @(negedge r_clk);
      if (c == 2) begin
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ramp_up_busy got=%b exp=1", busy);
        end
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == c) begin
        e = sb_q.pop_front();
        n_tests++;
        if (lvl(0) !== e.lvl) begin
          n_fail++;
          $display("FAIL ramp_up_level cyc=%0d got=%0d exp=%0d", c, lvl(0), e.lvl);
        end
      end
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL ramp_up_timeout pending=%0d exp=0", sb_q.size());
    end
    repeat (3) @(negedge r_clk);
    n_tests++;
    if (busy !== 1'b0 || u_dut.u_ch_r.state !== ST_ON) begin
      n_fail++;
      $display("FAIL ramp_up_done busy=%b state=%0d exp busy=0 state=%0d", busy, u_dut.u_ch_r.state, ST_ON);
    end
    duty_q.push_back(eff_model(15));
    count_high(0, 16, hi);
    n_tests++;
    if (hi !== duty_q.pop_front()) begin
      n_fail++;
      $display("FAIL ramp_up_duty got=%0d exp=%0d", hi, eff_model(15));
    end
  endtask

  task automatic test_reverse();
    exp_t e;
    int   hi;
    bit   found;
    @(negedge r_clk);
    led_g = 1'b1;
    found = 1'b0;
    for (int i = 0; i < DIV * 10 && !found; i++) begin
      @(negedge r_clk);
      if (lvl(1) == 7) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reverse_reach7 got=%0d exp=7", lvl(1));
    end
    led_g = 1'b0;
    sb_q.delete();
    for (int k = 1; k <= 7; k++) sb_q.push_back('{cyc: DIV * k, lvl: 7 - k});
    for (int c = 1; c <= DIV * 7 + 2; c++) begin
      @(negedge r_clk);
      if (sb_q.size() > 0 && sb_q[0].cyc == c) begin
        e = sb_q.pop_front();
        n_tests++;
        if (lvl(1) !== e.lvl) begin
          n_fail++;
          $display("FAIL reverse_level cyc=%0d got=%0d exp=%0d", c, lvl(1), e.lvl);
        end
      end
    end
    n_tests++;
    if (u_dut.u_ch_g.state !== ST_OFF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reverse_final state=%0d busy=%b exp state=%0d busy=0", u_dut.u_ch_g.state, busy, ST_OFF);
    end
    duty_q.push_back(0);
    count_high(1, 16, hi);
    n_tests++;
    if (hi !== duty_q.pop_front()) begin
      n_fail++;
      $display("FAIL reverse_led_off got=%0d exp=0", hi);
    end
  endtask

  task automatic test_duty();
    int  targets[3];
    int  hi;
    int  exp_hi;
    bit  found;
    targets = '{3, 4, 8};
    @(negedge r_clk);
    rst_s   = 1'b1;
    led_b_s = 1'b1;
    foreach (targets[t]) begin
      found = 1'b0;
      for (int i = 0; i < DIV_S * 10 && !found; i++) begin
        @(negedge r_clk);
        if (lvl(3) == targets[t]) found = 1'b1;
      end
      n_tests++;
      if (!found) begin
        n_fail++;
        $display("FAIL duty_reach lvl=%0d got=%0d", targets[t], lvl(3));
      end
      duty_q.push_back(eff_model(targets[t]));
      repeat (4) @(negedge r_clk);
      count_high(3, 16, hi);
      exp_hi = duty_q.pop_front();
      n_tests++;
      if (hi !== exp_hi) begin
        n_fail++;
        $display("FAIL duty_level%0d got=%0d exp=%0d", targets[t], hi, exp_hi);
      end
      n_tests++;
      if (lvl(3) !== targets[t]) begin
        n_fail++;
        $display("FAIL duty_hold got=%0d exp=%0d", lvl(3), targets[t]);
      end
    end
    led_b_s = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit   found;
    @(negedge r_clk);
    led_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < DIV * 12 && !found; i++) begin
      @(negedge r_clk);
      if (lvl(2) == 9) found = 1'b1;
    end
    n_tests++;
    if (!found || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_reach9 got=%0d busy=%b exp=9 busy=1", lvl(2), busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_r, out_g, out_b, busy} !== 4'b0000 || lvl(2) !== 0) begin
      n_fail++;
      $display("FAIL areset_async outs=%b lvl=%0d exp outs=0000 lvl=0", {out_r, out_g, out_b, busy}, lvl(2));
    end
    @(negedge r_clk);
    rst_n = 1'b1;
    sb_q.delete();
    sb_q.push_back('{cyc: DIV - 1, lvl: 0});
    sb_q.push_back('{cyc: DIV,     lvl: 1});
    sb_q.push_back('{cyc: 2 * DIV, lvl: 2});
    for (int c = 1; c <= 2 * DIV + 1; c++) begin
      @(negedge r_clk);
      if (sb_q.size() > 0 && sb_q[0].cyc == c) begin
        e = sb_q.pop_front();
        n_tests++;
        if (lvl(2) !== e.lvl) begin
          n_fail++;
          $display("FAIL areset_restart cyc=%0d got=%0d exp=%0d", c, lvl(2), e.lvl);
        end
      end
    end
    led_r = 1'b0;
    led_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_reverse();
    test_duty();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
